// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: stall sequencing, branch flush priority, forwarding select and event counters.
// Optional feature: define PIPELINE_FORWARD_EN to enable EX forwarding (only load-use then stalls, for one cycle).
module pipeline_hazard_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        mem_pcsrc,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

`ifdef PIPELINE_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  state_t      state_r, state_next_s;
  logic [1:0]  rem_r, rem_next_s;
  logic [1:0]  depth_s;
  logic        ex_match_s, mem_match_s, wb_match_s;
  logic        stall_s, flush_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [15:0] stall_cnt_r, flush_cnt_r;

  // A written, nonzero destination that feeds one of the ID sources.
  function automatic logic src_match(input logic wr, input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return wr && (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // MEM result wins over WB data when both hold the operand.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] mrd, input logic mrw,
                                         input logic [4:0] wrd, input logic wrw);
    if (mrw && (mrd != 5'd0) && (mrd == src)) begin
      return 2'b10;
    end else if (wrw && (wrd != 5'd0) && (wrd == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard depth of the instruction in ID and forwarding selects for EX.
  always_comb begin
    ex_match_s  = src_match(ex_regwrite, ex_rd, id_rs, id_rt, id_uses_rt);
    mem_match_s = src_match(mem_regwrite, mem_rd, id_rs, id_rt, id_uses_rt);
    wb_match_s  = src_match(wb_regwrite, wb_rd, id_rs, id_rt, id_uses_rt);
    depth_s     = 2'd0;
    if (FWD_EN) begin
      if (ex_memread && ex_match_s) begin
        depth_s = 2'd1;
      end else begin
        depth_s = 2'd0;
      end
    end else if (ex_match_s) begin
      depth_s = 2'd3;
    end else if (mem_match_s) begin
      depth_s = 2'd2;
    end else if (wb_match_s) begin
      depth_s = 2'd1;
    end else begin
      depth_s = 2'd0;
    end
    fwd_a_s = FWD_EN ? fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
    fwd_b_s = FWD_EN ? fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
  end

  // Next state / remaining-stall logic; a taken branch overrides any stall.
  always_comb begin
    state_next_s = state_r;
    rem_next_s   = rem_r;
    stall_s      = 1'b0;
    flush_s      = 1'b0;
    if (mem_pcsrc) begin
      flush_s      = 1'b1;
      state_next_s = ST_RUN;
      rem_next_s   = 2'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (depth_s != 2'd0) begin
            stall_s      = 1'b1;
            rem_next_s   = depth_s - 2'd1;
            state_next_s = (depth_s > 2'd1) ? ST_STALL : ST_RUN;
          end else begin
            rem_next_s   = 2'd0;
            state_next_s = ST_RUN;
          end
        end
        ST_STALL: begin
          stall_s      = 1'b1;
          rem_next_s   = rem_r - 2'd1;
          state_next_s = (rem_r > 2'd1) ? ST_STALL : ST_RUN;
        end
        default: begin
          state_next_s = ST_RUN;
          rem_next_s   = 2'd0;
        end
      endcase
    end
  end

  // Stall/flush outputs must act in the same cycle, so they stay combinational with reset forcing.
  always_comb begin
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end else begin
      pc_write    = ~stall_s;
      ifid_write  = ~stall_s;
      idex_bubble = stall_s;
      flush_ifid  = flush_s;
      flush_idex  = flush_s;
      flush_exmem = flush_s;
      fwd_a       = fwd_a_s;
      fwd_b       = fwd_b_s;
    end
  end

  // State, remaining stall count and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      rem_r       <= 2'd0;
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      rem_r   <= rem_next_s;
      if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
      if (flush_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: vector table plus flush and reset sequences.
// Expectations follow PIPELINE_FORWARD_EN when the bench is built with it.
module tb_pipeline_hazard_controller;

`ifdef PIPELINE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, mem_pcsrc, wb_regwrite;
  logic        pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [4:0] id_rs;  logic [4:0] id_rt;  logic uses;
    logic [4:0] ex_rs;  logic [4:0] ex_rt;  logic [4:0] ex_rd; logic ex_rw; logic ex_mr;
    logic [4:0] mem_rd; logic mem_rw;
    logic [4:0] wb_rd;  logic wb_rw;
    int         d_nofwd; int d_fwd;
    logic [1:0] fa;     logic [1:0] fb;
  } vec_t;

  vec_t       vecs[12];
  logic [9:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         model_stall = 0;
  int         model_flush = 0;

  pipeline_hazard_controller dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_pcsrc(mem_pcsrc),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; mem_pcsrc = 1'b0;
    wb_rd = 5'd0; wb_regwrite = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.uses;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd; ex_regwrite = v.ex_rw; ex_memread = v.ex_mr;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_rw; mem_pcsrc = 1'b0;
    wb_rd = v.wb_rd; wb_regwrite = v.wb_rw;
  endtask

  // Expected output bundle: {pc_write, ifid_write, idex_bubble, 3 x flush, fwd_a, fwd_b}.
  task automatic push_exp(input logic stall, input logic flush, input logic [1:0] fa, input logic [1:0] fb);
    exp_q.push_back({~stall, ~stall, stall, flush, flush, flush, fa, fb});
  endtask

  task automatic pop_check(input string name);
    logic [9:0] act;
    act = {pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b};
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, act);
    end else begin
      chk(name, {22'd0, act}, {22'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    int d;
    int n;
    vec_t v;
    //            id_rs  id_rt  u     ex_rs  ex_rt  ex_rd  rw    mr    mem_rd mrw   wb_rd  wrw   nf fw fa     fb
    vecs[0]  = '{5'd1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3, 1, 2'b00, 2'b00};
    vecs[1]  = '{5'd1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3, 0, 2'b00, 2'b00};
    vecs[2]  = '{5'd0, 5'd4, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 2, 0, 2'b10, 2'b00};
    vecs[3]  = '{5'd7, 5'd0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1, 0, 2'b00, 2'b01};
    vecs[4]  = '{5'd0, 5'd3, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 0, 0, 2'b00, 2'b00};
    vecs[6]  = '{5'd5, 5'd6, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3, 0, 2'b00, 2'b00};
    vecs[7]  = '{5'd2, 5'd0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 0, 0, 2'b00, 2'b00};
    vecs[8]  = '{5'd0, 5'd9, 1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 5'd2, 1'b1, 0, 0, 2'b00, 2'b10};
    vecs[9]  = '{5'd0, 5'd9, 1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 5'd2, 1'b1, 0, 0, 2'b00, 2'b01};
    vecs[10] = '{5'd0, 5'd8, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3, 1, 2'b00, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 0, 0, 2'b01, 2'b00};

    // Reset with busy inputs, including a taken branch: outputs must sit at reset values.
    rst = 1'b1;
    apply(vecs[2]);
    mem_pcsrc = 1'b1;
    exp_q.push_back(10'b0010000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    pop_check("reset_outs");
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    set_idle();
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      d = FWD ? v.d_fwd : v.d_nofwd;
      apply(v);
      push_exp(d > 0, 1'b0, FWD ? v.fa : 2'b00, FWD ? v.fb : 2'b00);
      @(negedge clk);
      pop_check($sformatf("vec%0d_out", i));
      @(posedge clk); #1;
      set_idle();
      n = (d > 0) ? 1 : 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (pc_write) break;
        n++;
        @(posedge clk); #1;
      end
      model_stall += d;
      chk($sformatf("vec%0d_stall_len", i), n, d);
      chk($sformatf("vec%0d_stall_cnt", i), {16'd0, stall_cnt}, model_stall);
      @(posedge clk); #1;
    end

    // Taken branch one cycle into a load-use stall (rem=2 without forwarding).
    apply(vecs[0]);
    push_exp(1'b1, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("flush_seq_stall");
    @(posedge clk); #1;
    model_stall += 1;
    set_idle();
    mem_pcsrc = 1'b1;
    push_exp(1'b0, 1'b1, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("flush_in_stall");
    @(posedge clk); #1;
    model_flush += 1;
    mem_pcsrc = 1'b0;
    push_exp(1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("run_after_flush");
    chk("flush_cnt_after_flush", {16'd0, flush_cnt}, model_flush);
    chk("stall_cnt_after_flush", {16'd0, stall_cnt}, model_stall);
    @(posedge clk); #1;

    // Taken branch in the same cycle as a new hazard: no stall at all.
    apply(vecs[1]);
    mem_pcsrc = 1'b1;
    push_exp(1'b0, 1'b1, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("flush_beats_hazard");
    @(posedge clk); #1;
    model_flush += 1;
    set_idle();
    push_exp(1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("no_stall_after_flush");
    chk("flush_cnt_second", {16'd0, flush_cnt}, model_flush);
    chk("stall_cnt_unchanged", {16'd0, stall_cnt}, model_stall);
    @(posedge clk); #1;

    // Reset pulsed in the middle of a stall.
    apply(vecs[1]);
    d = FWD ? vecs[1].d_fwd : vecs[1].d_nofwd;
    push_exp(d > 0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("pre_reset_hazard");
    @(posedge clk); #1;
    set_idle();
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(10'b0010000000);
    pop_check("reset_mid_stall");
    chk("reset_mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset_mid_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    pop_check("run_after_reset");
    @(posedge clk); #1;
    chk("stall_cnt_after_reset", {16'd0, stall_cnt}, 32'd0);
    chk("flush_cnt_after_reset", {16'd0, flush_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
